// File: rtl/fas_serial_if.sv
// fas_serial_if: operand/result bundle for the bit-serial add/subtract controller
interface fas_serial_if #(parameter int N = 8);
  logic start, a_ns, busy, done, cout, ovf;
  logic [N-1:0] a, b, s;
  modport master(output start, a_ns, a, b, input busy, done, s, cout, ovf);
  modport slave(input start, a_ns, a, b, output busy, done, s, cout, ovf);
endinterface

// File: rtl/fas_serial_ctrl.sv
// fas_serial_ctrl: bit-serial adder/subtractor reusing one fas cell, LSB first
module fas (
  input  logic a,
  input  logic b,
  input  logic cin,
  input  logic a_ns,
  output logic s,
  output logic cout
);
  assign s = a ^ b ^ cin;
  assign cout = a_ns ? (a & b) | (a & cin) | (b & cin) : (~a & (b | cin)) | (b & cin);
endmodule

module fas_serial_ctrl #(parameter int N = 8) (
  input logic clk,
  input logic rst,
  fas_serial_if.slave io
);
  localparam int CW = $clog2(N);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state_q, state_d;
  logic [N-1:0] a_q, a_d, b_q, b_d, r_q, r_d, s_q, s_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic op_q, op_d, c_q, c_d, busy_q, busy_d, done_q, done_d;
  logic cout_q, cout_d, ovf_q, ovf_d, cs, cc, last;
  fas u_fas (.a(a_q[0]), .b(b_q[0]), .cin(c_q), .a_ns(op_q), .s(cs), .cout(cc));
  assign last = cnt_q == CW'(N - 1);
  always_comb begin
    state_d = state_q;
    a_d = a_q;
    b_d = b_q;
    r_d = r_q;
    s_d = s_q;
    cnt_d = cnt_q;
    op_d = op_q;
    c_d = c_q;
    cout_d = cout_q;
    ovf_d = ovf_q;
    if (state_q == RUN) begin
      r_d = {cs, r_q[N-1:1]};
      c_d = cc;
      a_d = a_q >> 1;
      b_d = b_q >> 1;
      cnt_d = cnt_q + 1'b1;
      if (last) begin
        s_d = {cs, r_q[N-1:1]};
        cout_d = cc;
        ovf_d = c_q ^ cc;
        cnt_d = '0;
        state_d = DONE;
      end
    end else begin
      state_d = io.start ? RUN : IDLE;
      if (io.start) begin
        a_d = io.a;
        b_d = io.b;
        op_d = io.a_ns;
        c_d = 1'b0;
        cnt_d = '0;
      end
    end
    busy_d = state_d == RUN;
    done_d = state_d == DONE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q <= '0;
      b_q <= '0;
      r_q <= '0;
      s_q <= '0;
      cnt_q <= '0;
      op_q <= 1'b0;
      c_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      cout_q <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q <= a_d;
      b_q <= b_d;
      r_q <= r_d;
      s_q <= s_d;
      cnt_q <= cnt_d;
      op_q <= op_d;
      c_q <= c_d;
      busy_q <= busy_d;
      done_q <= done_d;
      cout_q <= cout_d;
      ovf_q <= ovf_d;
    end
  end
  assign io.busy = busy_q;
  assign io.done = done_q;
  assign io.s = s_q;
  assign io.cout = cout_q;
  assign io.ovf = ovf_q;
endmodule

// File: doc/fas_serial_ctrl.md
FAS_SERIAL_CTRL -- requirements
Module: fas_serial_ctrl

Interface
REQ-001 Parameter: N, default 8, operand width in bits (2..32).
REQ-002 clk  in  1  single clock, all state updates on rising edge.
REQ-003 rst  in  1  synchronous, active-high reset.
REQ-004 start  in  1  request to begin an operation; sampled only when not busy.
REQ-005 a_ns  in  1  op select: 1 = add (A+B), 0 = subtract (A-B); latched with start.
REQ-006 a  in  N  operand A, latched with start.
REQ-007 b  in  N  operand B, latched with start.
REQ-008 busy  out  1  high while bits are being processed.
REQ-009 done  out  1  one-cycle pulse, result valid.
REQ-010 s  out  N  result (sum or difference), registered.
REQ-011 cout  out  1  final carry (add) or final borrow (subtract).
REQ-012 ovf  out  1  two's-complement signed overflow.

Function
REQ-013 Datapath: exactly one fas bit cell, reused serially, LSB first; ports a, b, cin, a_ns, s, cout of the cell driven from internal shift registers, the carry flop and the latched op.
REQ-014 Cell semantics relied on: a_ns=1 gives s=a^b^cin and cout=majority(a,b,cin); a_ns=0 gives s=a^b^cin and cout=borrow=(~a&(b|cin))|(b&cin).
REQ-015 FSM states: IDLE, RUN, DONE; encoding free.
REQ-016 IDLE: start=1 at edge E0 -> latch a, b, a_ns; clear carry flop to 0; bit counter to 0; go RUN.
REQ-017 RUN: each edge E1..EN captures the cell's s bit into result shift register and cell cout into carry flop; shift operands right; increment counter.
REQ-018 At edge EN (counter = N-1): load s from result shift register, cout from cell cout, ovf = (carry into MSB) XOR (carry out of MSB); go DONE.
REQ-019 busy = 1 exactly in RUN (cycles after E0 through EN); done = 1 exactly in DONE (one cycle).
REQ-020 DONE: start=1 -> accepted as in IDLE (back-to-back, no idle cycle); start=0 -> IDLE.
REQ-021 start while in RUN is ignored; no queuing; latched operands and op unchanged.
REQ-022 Changes on a, b, a_ns after E0 do not affect the running operation.
REQ-023 s, cout, ovf hold the last completed result through IDLE and the entire next RUN; update only at EN.
REQ-024 Latency: start sampled at E0 -> done high in the cycle following EN; throughput one op per N+1 cycles back-to-back.
REQ-025 Arithmetic modulo 2^N; no saturation; cout and ovf are the only range indicators.
REQ-026 Clock period >= 40 time units, covering the cell's worst-case combinational path with margin.

Reset
REQ-027 rst=1 at an edge -> state IDLE, busy=0, done=0, s=0, cout=0, ovf=0, carry flop=0, counter=0; takes priority over start.
REQ-028 rst mid-RUN aborts the operation: no done pulse, outputs forced to reset values, next start after rst release runs normally.

Verification (N=8)
REQ-029 add 0x35+0x4A, start one cycle -> busy 8 cycles, done pulse 8 cycles after start cycle, s=0x7F cout=0 ovf=0.
REQ-030 add 0x7F+0x01 -> s=0x80 cout=0 ovf=1; then add 0xFF+0x01 -> s=0x00 cout=1 ovf=0.
REQ-031 sub 0x10-0x20 -> s=0xF0 cout=1 ovf=0; sub 0x80-0x01 -> s=0x7F cout=0 ovf=1.
REQ-032 start held high continuously with changing operands -> ops run back-to-back, one every 9 cycles, each result matches operands present on its accepting edge; mid-RUN operand changes ignored.
REQ-033 rst asserted at 4th RUN cycle -> no done, all outputs 0, IDLE next cycle; subsequent add 0x01+0x01 -> s=0x02.
REQ-034 prior result s=0x7F held stable throughout a following RUN until its EN edge.
